// File: rtl/mic1_uart_tx.sv
// mic1_uart_tx -- buffered 8N1 UART transmitter for the MIC-1 SoC serial path.
//
// Bytes enter a small circular FIFO through a valid/ready handshake. A
// baud-divided serialiser drains the FIFO onto ser_tx: one start bit (0),
// eight data bits LSB first, and one stop bit (1), each held bit_div clocks.
// The clocks-per-bit divider is runtime-writable. A new value applies from
// the next frame start, and values 0 and 1 are clamped to 2.
//
// Ports:
//   clk        in   system clock, single domain
//   resetn     in   synchronous active-low reset
//   div_we     in   divider write strobe
//   div_wdata  in   new clocks-per-bit value (16 bit)
//   tx_valid   in   producer has a byte
//   tx_data    in   byte to send
//   tx_ready   out  FIFO not full; byte transfers when tx_valid && tx_ready
//   fifo_level out  bytes queued, excluding the byte being shifted out
//   tx_busy    out  frame in progress or bytes queued
//   ser_tx     out  serial line, idles high
module mic1_uart_tx #(
  parameter int DEFAULT_DIV = 104,
  parameter int FIFO_DEPTH  = 8,
  parameter int LEVEL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_we,
  input  logic [15:0]        div_wdata,
  input  logic               tx_valid,
  input  logic [7:0]         tx_data,
  output logic               tx_ready,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               tx_busy,
  output logic               ser_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and pointers (one extra bit distinguishes full from empty)
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] ptr_diff;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  // Divider and serialiser state
  logic [15:0] div_reg;
  logic [15:0] div_eff;
  state_t      state, state_n;
  logic        ser_n;
  logic [7:0]  shift, shift_n;
  logic [15:0] bit_div, bit_div_n;
  logic [15:0] cyc_cnt, cyc_n;
  logic [2:0]  bit_cnt, bit_n;
  logic        bit_done;

  assign ptr_diff   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Ready reflects registered fullness only; a same-cycle pop does not free
  // a slot for the producer until the following cycle.
  assign tx_ready   = !fifo_full;
  assign push       = tx_valid && !fifo_full;
  assign fifo_level = LEVEL_W'(ptr_diff);
  assign tx_busy    = (state != S_IDLE) || !fifo_empty;

  assign div_eff    = (div_reg < 16'd2) ? 16'd2 : div_reg;
  assign bit_done   = (cyc_cnt == bit_div - 16'd1);

  // Next-state and datapath logic for the serialiser.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_n   = state;
    ser_n     = ser_tx;
    shift_n   = shift;
    bit_div_n = bit_div;
    cyc_n     = cyc_cnt + 16'd1;
    bit_n     = bit_cnt;
    pop       = 1'b0;

    unique case (state)
      S_IDLE: begin
        cyc_n = 16'd0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_n   = head;
          bit_div_n = div_eff;
          bit_n     = 3'd0;
          ser_n     = 1'b0;
          state_n   = S_START;
        end
      end

      S_START: begin
        if (bit_done) begin
          cyc_n   = 16'd0;
          ser_n   = shift[0];
          state_n = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cyc_n = 16'd0;
          if (bit_cnt == 3'd7) begin
            ser_n   = 1'b1;
            state_n = S_STOP;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            ser_n   = shift[1];
          end
        end
      end

      S_STOP: begin
        if (bit_done) begin
          cyc_n = 16'd0;
          // Chain straight into the next start bit so back-to-back frames
          // are exactly ten bit times apart.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_n   = head;
            bit_div_n = div_eff;
            bit_n     = 3'd0;
            ser_n     = 1'b0;
            state_n   = S_START;
          end else begin
            ser_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end

      default: begin
        ser_n   = 1'b1;
        cyc_n   = 16'd0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (!resetn) begin
      state   <= S_IDLE;
      ser_tx  <= 1'b1;
      shift   <= 8'd0;
      bit_div <= 16'd2;
      cyc_cnt <= 16'd0;
      bit_cnt <= 3'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      div_reg <= 16'(DEFAULT_DIV);
    end else begin
      state   <= state_n;
      ser_tx  <= ser_n;
      shift   <= shift_n;
      bit_div <= bit_div_n;
      cyc_cnt <= cyc_n;
      bit_cnt <= bit_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (div_we) div_reg <= div_wdata;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the byte array is deliberately not reset; resetting the pointers
    // already marks every entry invalid, and unreset storage maps onto RAM.
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

endmodule

// File: tb/tb_mic1_uart_tx.sv
// tb_mic1_uart_tx -- directed self-checking bench for mic1_uart_tx.
//
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point. "Cycle n" is the interval following the edge
// that accepted the first byte of a scenario (edge 0).
module tb_mic1_uart_tx;

  localparam int LEVEL_W = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic               div_we;
  logic [15:0]        div_wdata;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic [LEVEL_W-1:0] fifo_level;
  logic               tx_busy;
  logic               ser_tx;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  mic1_uart_tx #(
    .DEFAULT_DIV(104),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div_we    (div_we),
    .div_wdata (div_wdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .fifo_level(fifo_level),
    .tx_busy   (tx_busy),
    .ser_tx    (ser_tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks ser_tx over frame offsets [from_c, to_c) of an 8N1 frame carrying
  // d with div clocks per bit, advancing one cycle per offset.
  task automatic expect_frame(input string tag, input logic [7:0] d, input int div,
                              input int from_c, input int to_c);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int c = from_c; c < to_c; c++) begin
      check($sformatf("%s@%0d", tag, c), 32'(ser_tx), 32'(fr[c / div]));
      step();
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input int div);
    expect_frame(tag, d, div, 0, 10 * div);
  endtask

  task automatic write_div(input logic [15:0] v);
    div_we    = 1'b1;
    div_wdata = v;
    step();
    div_we    = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    div_we    = 1'b0;
    div_wdata = 16'd0;
    tx_valid  = 1'b0;
    tx_data   = 8'd0;

    // Reset state
    step();
    step();
    check("rst_ser",   32'(ser_tx),     32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(tx_ready),   32'd1);
    check("rst_busy",  32'(tx_busy),    32'd0);
    resetn = 1'b1;
    step();
    check("idle_ser", 32'(ser_tx), 32'd1);

    // Single byte 0x55 at DIV=4
    write_div(16'd4);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    step();                       // cycle 0
    tx_valid = 1'b0;
    check("t1_level_c0", 32'(fifo_level), 32'd1);
    check("t1_ser_c0",   32'(ser_tx),     32'd1);
    check("t1_busy_c0",  32'(tx_busy),    32'd1);
    step();                       // cycle 1: start bit
    check("t1_level_c1", 32'(fifo_level), 32'd0);
    frame("t1_55", 8'h55, 4);     // cycles 1..40
    check("t1_busy_c41", 32'(tx_busy), 32'd0);
    check("t1_ser_c41",  32'(ser_tx),  32'd1);

    // Back-to-back 0xA5, 0x0F at DIV=4: second start bit at cycle 41
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step();                       // cycle 0
    tx_data  = 8'h0F;
    step();                       // cycle 1
    tx_valid = 1'b0;
    check("t2_level_c1", 32'(fifo_level), 32'd1);
    frame("t2_a5", 8'hA5, 4);
    frame("t2_0f", 8'h0F, 4);
    check("t2_busy_end", 32'(tx_busy), 32'd0);

    // FIFO full at DIV=100
    write_div(16'd100);
    tx_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tx_data = 8'(k);
      step();
    end                           // cycle 8
    check("t3_level_full", 32'(fifo_level), 32'd8);
    check("t3_ready_full", 32'(tx_ready),   32'd0);
    tx_data = 8'h09;
    expect_frame("t3_b0", 8'h00, 100, 7, 999);
    check("t3_level_c1000", 32'(fifo_level), 32'd8);
    check("t3_ready_c1000", 32'(tx_ready),   32'd0);
    expect_frame("t3_b0", 8'h00, 100, 999, 1000);
    check("t3_level_c1001", 32'(fifo_level), 32'd7);
    check("t3_ready_c1001", 32'(tx_ready),   32'd1);
    expect_frame("t3_b1", 8'h01, 100, 0, 1);
    tx_valid = 1'b0;
    check("t3_level_c1002", 32'(fifo_level), 32'd8);
    expect_frame("t3_b1", 8'h01, 100, 1, 1000);
    for (int k = 2; k < 10; k++) frame($sformatf("t3_b%0d", k), 8'(k), 100);
    check("t3_busy_end",  32'(tx_busy),    32'd0);
    check("t3_level_end", 32'(fifo_level), 32'd0);

    // Divider change mid-frame: 0xFF at DIV=8, div=16 written during bit 3
    write_div(16'd8);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    step();                       // cycle 0
    tx_data  = 8'h3C;
    step();                       // cycle 1
    tx_valid = 1'b0;
    expect_frame("t4_ff", 8'hFF, 8, 0, 32);
    div_we    = 1'b1;
    div_wdata = 16'd16;
    expect_frame("t4_ff", 8'hFF, 8, 32, 33);
    div_we    = 1'b0;
    expect_frame("t4_ff", 8'hFF, 8, 33, 80);
    frame("t4_3c", 8'h3C, 16);
    check("t4_busy_end", 32'(tx_busy), 32'd0);

    // Divider clamp: div=0 behaves as 2
    write_div(16'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    step();
    tx_valid = 1'b0;
    step();
    frame("t5_01", 8'h01, 2);
    check("t5_busy_end", 32'(tx_busy), 32'd0);

    // Reset mid-frame with bytes queued
    write_div(16'd4);
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    step();                       // cycle 0
    tx_data  = 8'h22;
    step();                       // cycle 1
    tx_data  = 8'h33;
    step();                       // cycle 2
    tx_valid = 1'b0;
    check("t6_level_c2", 32'(fifo_level), 32'd2);
    expect_frame("t6_11", 8'h11, 4, 1, 9);
    check("t6_level_c10", 32'(fifo_level), 32'd2);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("t6_ser",   32'(ser_tx),     32'd1);
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_busy",  32'(tx_busy),    32'd0);
    check("t6_ready", 32'(tx_ready),   32'd1);
    step();
    step();
    check("t6_ser_after",  32'(ser_tx),  32'd1);
    check("t6_busy_after", 32'(tx_busy), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h96;
    step();
    tx_valid = 1'b0;
    step();
    frame("t6_96", 8'h96, 104);   // divider back to its reset value
    check("t6_busy_end", 32'(tx_busy), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mic1_uart_tx.md
Name: mic1_uart_tx

Overview:
Buffered UART transmitter that drives the iCEBreaker TX pin from the MIC-1 SoC's serial output path. It replaces the constant-high TX tie-off. The SoC pushes bytes through a valid/ready handshake into a small FIFO. A baud-divided 8N1 serialiser drains the FIFO onto ser_tx. The divider is runtime-writable, so firmware can change baud without resynthesis.

Parameters:
DEFAULT_DIV, 104, clocks per bit after reset (12 MHz / 115200 ≈ 104)
FIFO_DEPTH, 8, byte entries in the TX FIFO; power of two, ≥2
LEVEL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level

Ports:
clk  in  1  system clock, single domain
resetn  in  1  synchronous active-low reset
div_we  in  1  write strobe for baud divider
div_wdata  in  16  new clocks-per-bit value
tx_valid  in  1  producer has a byte
tx_data  in  8  byte to send
tx_ready  out  1  FIFO can accept; transfer when tx_valid && tx_ready at posedge
fifo_level  out  LEVEL_W  bytes currently queued, not counting the byte in flight
tx_busy  out  1  frame in progress or FIFO non-empty
ser_tx  out  1  serial line, idle high

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values (resetn=0 at posedge): ser_tx=1, state=IDLE, FIFO empty, fifo_level=0, tx_ready=1, tx_busy=0, divider=DEFAULT_DIV, bit/cycle counters=0.
- Reset mid-frame aborts the frame. ser_tx is high from the next cycle and queued bytes are discarded.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - tx_ready = !full. tx_ready is registered-state based and does not look ahead at a same-cycle pop.
  - Accepted write at posedge: level+1 visible the following cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - A push is impossible when full. A pop when empty never occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- Divider:
  - div_we latches div_wdata into the divider register at posedge.
  - Values 0 and 1 are treated as 2.
  - The active frame uses bit_div, latched at frame start. A divider write mid-frame takes effect from the next frame.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE and FIFO non-empty at posedge: pop head into shift register, latch bit_div, go to START, ser_tx<=0 at the same edge.
  - START: hold for bit_div cycles, then DATA, ser_tx<=shift[0].
  - DATA: 8 bits, LSB first, each held bit_div cycles; shift right per bit. After bit 7, go to STOP, ser_tx<=1.
  - STOP: hold bit_div cycles.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START. There is no idle gap, so back-to-back frames are exactly 10*bit_div cycles.
    - Otherwise go to IDLE, ser_tx stays 1.
- Latency: a byte written at posedge n into an empty, idle FIFO drives the start bit from posedge n+1.
- tx_busy = (state != IDLE) || (fifo_level != 0). It is combinational from registered state.
- Counters:
  - cycle counter is 16-bit, counts 0..bit_div-1.
  - bit counter is 3-bit.
  - No overflow is possible within these ranges.

Test Plan:
- Single byte, DIV=4: write 0x55 at cycle 0. ser_tx reads 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles, from cycles 1–40. tx_busy falls at cycle 41. fifo_level is 1 for exactly one cycle.
- Back-to-back, DIV=4: write 0xA5 then 0x0F on consecutive cycles. Frames are contiguous, with the second start bit beginning at cycle 41 and no idle high between frames. Bit order is LSB first.
- FIFO full, DIV=100: 10 consecutive writes 0x00..0x09 with tx_valid held.
  - First byte pops; 8 more fill the FIFO, so fifo_level=8 and tx_ready=0.
  - The 10th byte stalls until the first frame ends, then is accepted.
  - All 10 bytes emerge in order.
- Divider change mid-frame: at DIV=8, send 0xFF. Write div=16 during bit 3. The current frame keeps 8-cycle bits; the next byte's bits are 16 cycles.
- Divider clamp: write div=0, send 0x01. Each bit lasts 2 cycles.
- Reset mid-frame: queue 3 bytes, assert resetn=0 for one cycle during DATA. Next cycle: ser_tx=1, fifo_level=0, tx_busy=0, tx_ready=1, divider=DEFAULT_DIV. A subsequent write transmits normally.
